// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with boot loader for a 64x16 async-read instruction memory.
// Optional FETCH_PERF_EN adds a saturating fetch_count output.
module fetch_ctrl #(
    parameter int addWidth = 6,
    parameter int dataWidth = 16,
    parameter logic [dataWidth-1:0] HALT_WORD = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boot_start,
    input  logic                 boot_valid,
    input  logic [dataWidth-1:0] boot_data,
    input  logic                 boot_last,
    input  logic                 run,
    input  logic                 stall,
    input  logic                 resume,
    input  logic                 branch_taken,
    input  logic [addWidth-1:0]  branch_target,
    output logic [addWidth-1:0]  mem_addr,
    output logic                 mem_we,
    output logic                 mem_en,
    output logic [dataWidth-1:0] mem_di,
    input  logic [dataWidth-1:0] mem_instr,
    output logic [dataWidth-1:0] ir,
    output logic [addWidth-1:0]  ir_pc,
    output logic                 ir_valid,
    output logic [addWidth-1:0]  pc,
`ifdef FETCH_PERF_EN
    output logic [15:0]          fetch_count,
`endif
    output logic                 boot_done,
    output logic                 halted
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
    localparam logic [addWidth-1:0] LAST_ADDR = '1;
    state_t state_q, state_d;
    logic [addWidth-1:0] pc_q, pc_d, cnt_q, cnt_d, ir_pc_q, ir_pc_d;
    logic [dataWidth-1:0] ir_q, ir_d;
    logic ir_valid_q, ir_valid_d, boot_done_q, boot_done_d, halted_q, halted_d;
    logic [15:0] fc_q, fc_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            cnt_q       <= '0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            boot_done_q <= 1'b0;
            halted_q    <= 1'b0;
            fc_q        <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            boot_done_q <= boot_done_d;
            halted_q    <= halted_d;
            fc_q        <= fc_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        boot_done_d = 1'b0;
        halted_d    = halted_q;
        fc_d        = fc_q;
        mem_addr    = pc_q;
        mem_we      = 1'b0;
        mem_en      = 1'b0;
        mem_di      = '0;
        case (state_q)
            IDLE: begin
                if (boot_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (run) begin
                    state_d = RUN;
                    pc_d    = '0;
                    fc_d    = '0;
                end
            end
            LOAD: begin
                mem_addr = cnt_q;
                mem_di   = boot_data;
                mem_we   = boot_valid;
                mem_en   = boot_valid;
                // the write at the top address ends the load even without boot_last
                if (boot_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (boot_last || cnt_q == LAST_ADDR) begin
                        state_d     = IDLE;
                        boot_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                mem_en = 1'b1;
                if (branch_taken) begin
                    pc_d       = branch_target;
                    ir_valid_d = 1'b0;
                end else if (!stall) begin
                    if (mem_instr == HALT_WORD) begin
                        ir_valid_d = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = HALT;
                    end else begin
                        ir_d       = mem_instr;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + 1'b1;
                        fc_d       = fc_q + {15'd0, ~&fc_q};
                    end
                end
            end
            HALT: begin
                ir_valid_d = 1'b0;
                if (resume) begin
                    state_d  = RUN;
                    pc_d     = pc_q + 1'b1;
                    halted_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign boot_done = boot_done_q;
    assign halted    = halted_q;
`ifdef FETCH_PERF_EN
    assign fetch_count = fc_q;
`else
    logic unused_fc;
    assign unused_fc = ^fc_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table plus randomized run against a behavioural model of fetch_ctrl.
module tb_fetch_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic boot_start = 0, boot_valid = 0, boot_last = 0, run = 0, stall = 0, resume = 0, branch_taken = 0;
    logic [15:0] boot_data = '0;
    logic [5:0] branch_target = '0;
    logic [5:0] mem_addr, ir_pc, pc;
    logic mem_we, mem_en, ir_valid, boot_done, halted;
    logic [15:0] mem_di, mem_instr, ir;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif
    logic [15:0] mem [64];
    int tests = 0, fails = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .boot_start(boot_start), .boot_valid(boot_valid), .boot_data(boot_data),
        .boot_last(boot_last), .run(run), .stall(stall), .resume(resume), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_addr(mem_addr), .mem_we(mem_we), .mem_en(mem_en),
        .mem_di(mem_di), .mem_instr(mem_instr), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .pc(pc),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count),
`endif
        .boot_done(boot_done), .halted(halted)
    );

    always #5 clk = ~clk;
    assign mem_instr = mem[mem_addr];
    always @(posedge clk) if (mem_we && mem_en) mem[mem_addr] <= mem_di;

    // behavioural model: mode names plus architectural registers
    string m_mode;
    logic [5:0] m_pc, m_cnt, m_irpc;
    logic [15:0] m_ir;
    logic m_irv, m_h, m_bd;
    int m_fc;
    logic pre_we;
    logic [5:0] pre_addr;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = "idle"; m_pc = 0; m_cnt = 0; m_irpc = 0; m_ir = 0;
        m_irv = 0; m_h = 0; m_bd = 0; m_fc = 0;
    endtask

    task automatic check_regs();
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("ir_pc", ir_pc, m_irpc);
        chk("ir_valid", ir_valid, m_irv);
        chk("halted", halted, m_h);
        chk("boot_done", boot_done, m_bd);
`ifdef FETCH_PERF_EN
        chk("fetch_count", fetch_count, m_fc);
`endif
    endtask

    // one clock: check combinational outputs before the edge, advance the model, check registers after
    task automatic step();
        logic [15:0] w;
        bit ld;
        @(negedge clk);
        ld = (m_mode == "load");
        pre_we = mem_we;
        pre_addr = mem_addr;
        chk("mem_we", mem_we, ld && boot_valid);
        chk("mem_en", mem_en, (ld && boot_valid) || m_mode == "run");
        if (ld || m_mode == "run") chk("mem_addr", mem_addr, ld ? m_cnt : m_pc);
        chk("mem_di", mem_di, ld ? boot_data : 16'h0);
        w = mem[m_pc];
        m_bd = 0;
        if (rst) model_reset();
        else if (m_mode == "idle") begin
            if (boot_start) begin m_mode = "load"; m_cnt = 0; end
            else if (run) begin m_mode = "run"; m_pc = 0; m_fc = 0; end
        end else if (ld) begin
            if (boot_valid) begin
                if (boot_last || m_cnt == 63) begin m_mode = "idle"; m_bd = 1; end
                m_cnt = m_cnt + 1;
            end
        end else if (m_mode == "run") begin
            if (branch_taken) begin m_pc = branch_target; m_irv = 0; end
            else if (!stall) begin
                if (w == 16'hFFFF) begin m_irv = 0; m_h = 1; m_mode = "halt"; end
                else begin
                    m_ir = w; m_irpc = m_pc; m_irv = 1; m_pc = m_pc + 1;
                    m_fc = (m_fc == 65535) ? 65535 : m_fc + 1;
                end
            end
        end else if (resume) begin
            m_mode = "run"; m_pc = m_pc + 1; m_h = 0;
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    typedef struct {
        logic bs, bv; logic [15:0] bd; logic bl, rn, st, rs, bt; logic [5:0] tg;
        logic we; logic [5:0] addr;
        logic [5:0] pc; logic [15:0] ir; logic [5:0] irpc; logic irv, hlt, bdo;
    } vec_t;
    vec_t tab [22];

    initial begin
        tab[0]  = '{1,0,0,0,0,0,0,0,0,         0,0,  0,0,0,0,0,0};
        tab[1]  = '{0,1,16'h1111,0,0,0,0,0,0,  1,0,  0,0,0,0,0,0};
        tab[2]  = '{0,1,16'h2222,0,0,0,0,0,0,  1,1,  0,0,0,0,0,0};
        tab[3]  = '{0,1,16'h3333,0,0,0,0,0,0,  1,2,  0,0,0,0,0,0};
        tab[4]  = '{0,1,16'hFFFF,1,0,0,0,0,0,  1,3,  0,0,0,0,0,1};
        tab[5]  = '{0,0,0,0,0,0,0,0,0,         0,0,  0,0,0,0,0,0};
        tab[6]  = '{0,0,0,0,1,0,0,0,0,         0,0,  0,0,0,0,0,0};
        tab[7]  = '{0,0,0,0,0,0,0,0,0,         0,0,  1,16'h1111,0,1,0,0};
        tab[8]  = '{0,0,0,0,0,0,0,0,0,         0,1,  2,16'h2222,1,1,0,0};
        tab[9]  = '{0,0,0,0,0,0,0,0,0,         0,2,  3,16'h3333,2,1,0,0};
        tab[10] = '{0,0,0,0,0,0,0,0,0,         0,3,  3,16'h3333,2,0,1,0};
        tab[11] = '{0,0,0,0,0,1,0,1,9,         0,3,  3,16'h3333,2,0,1,0};
        tab[12] = '{0,0,0,0,0,0,1,0,0,         0,3,  4,16'h3333,2,0,0,0};
        tab[13] = '{0,0,0,0,0,0,0,0,0,         0,4,  5,16'h1004,4,1,0,0};
        tab[14] = '{0,0,0,0,0,1,0,0,0,         0,5,  5,16'h1004,4,1,0,0};
        tab[15] = '{0,0,0,0,0,1,0,0,0,         0,5,  5,16'h1004,4,1,0,0};
        tab[16] = '{0,0,0,0,0,1,0,0,0,         0,5,  5,16'h1004,4,1,0,0};
        tab[17] = '{0,0,0,0,0,1,0,1,40,        0,5,  40,16'h1004,4,0,0,0};
        tab[18] = '{0,0,0,0,0,0,0,0,0,         0,40, 41,16'h1028,40,1,0,0};
        tab[19] = '{0,0,0,0,0,0,0,1,63,        0,41, 63,16'h1028,40,0,0,0};
        tab[20] = '{0,0,0,0,0,0,0,0,0,         0,63, 0,16'h103F,63,1,0,0};
        tab[21] = '{0,0,0,0,0,0,0,0,0,         0,0,  1,16'h1111,0,1,0,0};
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_regs();
        rst = 0;
        for (int i = 0; i < 22; i++) begin
            {boot_start, boot_valid, boot_data, boot_last} = {tab[i].bs, tab[i].bv, tab[i].bd, tab[i].bl};
            {run, stall, resume, branch_taken, branch_target} = {tab[i].rn, tab[i].st, tab[i].rs, tab[i].bt, tab[i].tg};
            step();
            chk($sformatf("v%0d_we", i), pre_we, tab[i].we);
            chk($sformatf("v%0d_addr", i), pre_addr, tab[i].addr);
            chk($sformatf("v%0d_pc", i), pc, tab[i].pc);
            chk($sformatf("v%0d_ir", i), ir, tab[i].ir);
            chk($sformatf("v%0d_ir_pc", i), ir_pc, tab[i].irpc);
            chk($sformatf("v%0d_ir_valid", i), ir_valid, tab[i].irv);
            chk($sformatf("v%0d_halted", i), halted, tab[i].hlt);
            chk($sformatf("v%0d_boot_done", i), boot_done, tab[i].bdo);
`ifdef FETCH_PERF_EN
            if (i == 10) chk("fetch_count_at_halt", fetch_count, 3);
`endif
        end
        // reset in the middle of a load
        {run, stall, resume, branch_taken, boot_last} = '0;
        rst = 1; step(); rst = 0;
        boot_start = 1; step(); boot_start = 0;
        boot_valid = 1; boot_data = 16'hAAAA; step();
        boot_data = 16'hBBBB; step();
        boot_valid = 0; rst = 1; step(); rst = 0;
        chk("rst_load_pc", pc, 0);
        chk("rst_load_ir_valid", ir_valid, 0);
        chk("rst_load_boot_done", boot_done, 0);
        chk("rst_load_mem0", mem[0], 16'hAAAA);
        chk("rst_load_mem1", mem[1], 16'hBBBB);
        step();
        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom % 64) == 0;
            boot_start = ($urandom % 16) == 0;
            boot_valid = ($urandom % 4) != 0;
            boot_data = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
            boot_last = ($urandom % 20) == 0;
            run = ($urandom % 4) == 0;
            stall = ($urandom % 5) == 0;
            resume = ($urandom % 3) == 0;
            branch_taken = ($urandom % 10) == 0;
            branch_target = 6'($urandom);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
